// File: rtl/tick_bcd_counter.sv
// Purpose: synchronizes a slow divided clock (TICK_CLK), detects its rising edges and
//          counts them in a DIGITS-wide BCD counter under start/stop/clear control.
// Latency: TICK_CLK first sampled high at CLK_IN edge k -> TICK_SEEN/BCD_OUT update at k+SYNC_STAGES.
// Backpressure: none; every detected edge is acted on in the cycle it appears.
//
// Build option: define TICK_BCD_MINSEC_EN for MM:SS-style counting (odd-indexed digits
// roll over after 5, even-indexed digits after 9). Undefined: every digit rolls over after 9.
//
// Ports:
//   CLK_IN      system clock, all logic rising-edge
//   RESET_N     asynchronous active-low reset
//   TICK_CLK    slow asynchronous clock; only its rising edges matter
//   START_STOP  one-cycle pulse, toggles run/pause (IDLE -> RUN on first pulse)
//   CLEAR       one-cycle pulse, zeroes the count and returns to IDLE
//   BCD_OUT     count, digit 0 in BCD_OUT[3:0]
//   RUNNING     high while in RUN
//   TICK_SEEN   one-cycle pulse per detected TICK_CLK rising edge, in any state
//   WRAP        one-cycle pulse when the count rolls from all-max to zero
module tick_bcd_counter #(
   parameter int DIGITS      = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                CLK_IN,
   input  logic                RESET_N,
   input  logic                TICK_CLK,
   input  logic                START_STOP,
   input  logic                CLEAR,
   output logic [4*DIGITS-1:0] BCD_OUT,
   output logic                RUNNING,
   output logic                TICK_SEEN,
   output logic                WRAP
);

`ifdef TICK_BCD_MINSEC_EN
   localparam bit MINSEC_EN = 1'b1;
`else
   localparam bit MINSEC_EN = 1'b0;
`endif

   // The detector stays disarmed until the chain and history flop have been
   // filled with real samples, so a TICK_CLK already high at reset release
   // is not mistaken for a rising edge.
   localparam int                ARM_W      = $clog2(SYNC_STAGES + 2);
   localparam logic [ARM_W-1:0]  ARM_CYCLES = ARM_W'(SYNC_STAGES + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

   state_t                state_q;
   state_t                state_nxt;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic [ARM_W-1:0]       arm_cnt_q;
   logic                   armed;
   logic                   tick_edge;
   logic                   count_tick;

   logic [4*DIGITS-1:0]    cnt_q;
   logic [4*DIGITS-1:0]    cnt_inc;
   logic [4*DIGITS-1:0]    cnt_nxt;
   logic                   all_max;
   logic                   carry;
   logic                   wrap_nxt;

   function automatic logic [3:0] digit_max(input int idx);
      return (MINSEC_EN && (idx % 2 == 1)) ? 4'd5 : 4'd9;
   endfunction

   // ------------------------------------------------------------------
   // Synchronizer, edge history and arming counter
   // ------------------------------------------------------------------
   always_ff @(posedge CLK_IN or negedge RESET_N) begin
      if (!RESET_N) begin
         sync_q    <= '0;
         hist_q    <= 1'b0;
         arm_cnt_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], TICK_CLK};
         hist_q <= sync_q[SYNC_STAGES-1];
         if (!armed) begin
            arm_cnt_q <= arm_cnt_q + ARM_W'(1);
         end
      end
   end

   assign armed     = (arm_cnt_q == ARM_CYCLES);
   assign tick_edge = armed & sync_q[SYNC_STAGES-1] & ~hist_q;

   // CLEAR outranks a tick, so a tick arriving with CLEAR is dropped.
   assign count_tick = tick_edge & (state_q == ST_RUN) & ~CLEAR;

   // ------------------------------------------------------------------
   // BCD increment: ripple carry through all digits in one cycle.
   // all_max is the carry out of the top digit, i.e. the wrap condition.
   // ------------------------------------------------------------------
   always_comb begin
      cnt_inc = cnt_q;
      carry   = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (cnt_q[4*i +: 4] == digit_max(i)) begin
               cnt_inc[4*i +: 4] = 4'd0;
            end else begin
               cnt_inc[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
               carry             = 1'b0;
            end
         end
      end
      all_max = carry;
   end

   // ------------------------------------------------------------------
   // Control state machine: next state and datapath next values
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      wrap_nxt  = 1'b0;

      if (CLEAR) begin
         state_nxt = ST_IDLE;
         cnt_nxt   = '0;
      end else begin
         // The tick is evaluated against the current state, so a tick with
         // START_STOP in RUN is counted before moving to PAUSE, while one in
         // PAUSE/IDLE is not counted.
         if (count_tick) begin
            cnt_nxt  = cnt_inc;
            wrap_nxt = all_max;
         end
         if (START_STOP) begin
            case (state_q)
               ST_RUN:  state_nxt = ST_PAUSE;
               default: state_nxt = ST_RUN;
            endcase
         end
      end
   end

   always_ff @(posedge CLK_IN or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         RUNNING   <= 1'b0;
         TICK_SEEN <= 1'b0;
         WRAP      <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         cnt_q     <= cnt_nxt;
         // Decoded from the next state so RUNNING tracks state_q exactly.
         RUNNING   <= (state_nxt == ST_RUN);
         TICK_SEEN <= tick_edge;
         WRAP      <= wrap_nxt;
      end
   end

   assign BCD_OUT = cnt_q;

endmodule

// File: tb/tb_tick_bcd_counter.sv
// Purpose: self-checking bench for tick_bcd_counter; directed scenarios plus random
//          stimulus, compared every cycle against an arithmetic reference model.
// Latency: model predicts TICK_SEEN/BCD_OUT SYNC_STAGES edges after TICK_CLK is sampled high.
// Backpressure: n/a.
module tb_tick_bcd_counter;

   localparam int DG = 4;
   localparam int SS = 2;

`ifdef TICK_BCD_MINSEC_EN
   localparam bit MINSEC = 1'b1;
`else
   localparam bit MINSEC = 1'b0;
`endif

   localparam int S_IDLE  = 0;
   localparam int S_RUN   = 1;
   localparam int S_PAUSE = 2;

   logic            CLK_IN = 1'b0;
   logic            RESET_N;
   logic            TICK_CLK;
   logic            START_STOP;
   logic            CLEAR;
   logic [4*DG-1:0] BCD_OUT;
   logic            RUNNING;
   logic            TICK_SEEN;
   logic            WRAP;

   tick_bcd_counter #(
      .DIGITS      (DG),
      .SYNC_STAGES (SS)
   ) dut (
      .CLK_IN     (CLK_IN),
      .RESET_N    (RESET_N),
      .TICK_CLK   (TICK_CLK),
      .START_STOP (START_STOP),
      .CLEAR      (CLEAR),
      .BCD_OUT    (BCD_OUT),
      .RUNNING    (RUNNING),
      .TICK_SEEN  (TICK_SEEN),
      .WRAP       (WRAP)
   );

   always #5 CLK_IN = ~CLK_IN;

   int n_tests = 0;
   int n_fail  = 0;
   int n_seen  = 0;
   int n_wrap  = 0;

   // Reference model: count kept as a plain integer, rendered as digits by radix.
   int m_cnt;
   int m_state;
   bit m_seen;
   bit m_wrap;
   int edge_no;
   bit prev_samp;
   bit rise_at [0:32767];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int radix(input int i);
      return (MINSEC && (i % 2 == 1)) ? 6 : 10;
   endfunction

   function automatic int mod_max();
      int p = 1;
      for (int i = 0; i < DG; i++) p = p * radix(i);
      return p;
   endfunction

   function automatic logic [31:0] to_bcd(input int v);
      logic [31:0] r = '0;
      int          x = v;
      for (int i = 0; i < DG; i++) begin
         r[4*i +: 4] = 4'(x % radix(i));
         x           = x / radix(i);
      end
      return r;
   endfunction

   function automatic int val_of(input logic [31:0] b);
      int v = 0;
      int w = 1;
      for (int i = 0; i < DG; i++) begin
         v = v + int'(b[4*i +: 4]) * w;
         w = w * radix(i);
      end
      return v;
   endfunction

   task automatic model_reset();
      m_cnt     = 0;
      m_state   = S_IDLE;
      m_seen    = 1'b0;
      m_wrap    = 1'b0;
      edge_no   = 0;
      prev_samp = 1'b0;
   endtask

   // One CLK_IN rising edge of the reference model.
   task automatic model_edge(input logic tck, input logic s, input logic c);
      bit tk;
      edge_no++;
      rise_at[edge_no % 32768] = tck & ~prev_samp;
      prev_samp                = tck;
      // A rise sampled at edge k acts at edge k+SS; a rise sampled on the
      // very first edge after reset falls inside the disarmed window.
      tk     = (edge_no >= SS + 2) ? rise_at[(edge_no - SS) % 32768] : 1'b0;
      m_seen = tk;
      m_wrap = 1'b0;
      if (c) begin
         m_cnt   = 0;
         m_state = S_IDLE;
      end else begin
         if (m_state == S_RUN && tk) begin
            if (m_cnt == mod_max() - 1) begin
               m_cnt  = 0;
               m_wrap = 1'b1;
            end else begin
               m_cnt = m_cnt + 1;
            end
         end
         if (s) m_state = (m_state == S_RUN) ? S_PAUSE : S_RUN;
      end
   endtask

   // Starts and ends at a falling edge: drive, clock, compare everything.
   task automatic cyc(input logic tck, input logic s, input logic c);
      TICK_CLK   = tck;
      START_STOP = s;
      CLEAR      = c;
      @(posedge CLK_IN);
      model_edge(tck, s, c);
      #1;
      chk("bcd_out",   32'(BCD_OUT),   to_bcd(m_cnt));
      chk("running",   32'(RUNNING),   32'(m_state == S_RUN));
      chk("tick_seen", 32'(TICK_SEEN), 32'(m_seen));
      chk("wrap",      32'(WRAP),      32'(m_wrap));
      if (TICK_SEEN) n_seen++;
      if (WRAP)      n_wrap++;
      @(negedge CLK_IN);
   endtask

   // One TICK_CLK pulse; optional control pulse on cycle 'ev' (cycle 0 = rise sampled).
   task automatic tick_evt(input int hi, input int lo, input int ev, input logic s, input logic c);
      for (int j = 0; j < hi + lo; j++) begin
         cyc(j < hi, (j == ev) ? s : 1'b0, (j == ev) ? c : 1'b0);
      end
   endtask

   task automatic fast_ticks(input int n);
      repeat (n) tick_evt(1, 1, -1, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int   s0;
      int   w0;
      logic rnd_tck;

      // ---- reset with TICK_CLK already high ----
      RESET_N    = 1'b0;
      TICK_CLK   = 1'b1;
      START_STOP = 1'b0;
      CLEAR      = 1'b0;
      model_reset();
      repeat (3) @(negedge CLK_IN);
      chk("rst_bcd",     32'(BCD_OUT),   32'h0);
      chk("rst_running", 32'(RUNNING),   32'h0);
      chk("rst_seen",    32'(TICK_SEEN), 32'h0);
      chk("rst_wrap",    32'(WRAP),      32'h0);
      RESET_N = 1'b1;
      s0 = n_seen;
      repeat (10) cyc(1'b1, 1'b0, 1'b0);
      chk("arm_no_seen", 32'(n_seen - s0), 32'd0);
      chk("arm_bcd",     32'(BCD_OUT),     32'h0);
      chk("arm_running", 32'(RUNNING),     32'h0);

      // ---- start, 12 ticks of period 20 ----
      cyc(1'b0, 1'b1, 1'b0);
      chk("start_running", 32'(RUNNING), 32'h1);
      idle(2);
      s0 = n_seen;
      for (int j = 0; j < 20; j++) begin
         cyc(j < 10, 1'b0, 1'b0);
         if (j == SS - 1) chk("lat_early", 32'(TICK_SEEN), 32'h0);
         if (j == SS) begin
            chk("lat_seen", 32'(TICK_SEEN), 32'h1);
            chk("lat_bcd",  32'(BCD_OUT),   32'h0001);
         end
      end
      repeat (11) tick_evt(10, 10, -1, 1'b0, 1'b0);
      idle(3);
      chk("run12_seen", 32'(n_seen - s0), 32'd12);
      chk("run12_bcd",  32'(BCD_OUT),     32'h0012);
      chk("run12_run",  32'(RUNNING),     32'h1);

      // ---- pause holds count, ticks still seen ----
      cyc(1'b0, 1'b1, 1'b0);
      chk("pause_running", 32'(RUNNING), 32'h0);
      s0 = n_seen;
      repeat (5) tick_evt(10, 10, -1, 1'b0, 1'b0);
      chk("pause_seen", 32'(n_seen - s0), 32'd5);
      chk("pause_bcd",  32'(BCD_OUT),     32'h0012);
      tick_evt(1, 3, 0, 1'b1, 1'b0);
      idle(2);
      chk("resume_bcd", 32'(BCD_OUT), 32'h0013);
      chk("resume_run", 32'(RUNNING), 32'h1);

      // ---- CLEAR together with a tick at 0x0047 ----
      fast_ticks(val_of(32'h0047) - val_of(32'h0013));
      idle(4);
      chk("pre_clr_bcd", 32'(BCD_OUT), 32'h0047);
      w0 = n_wrap;
      tick_evt(1, 3, SS, 1'b0, 1'b1);
      chk("clr_tick_bcd",  32'(BCD_OUT),     32'h0000);
      chk("clr_tick_run",  32'(RUNNING),     32'h0);
      chk("clr_tick_wrap", 32'(n_wrap - w0), 32'd0);

      // ---- START_STOP together with a tick in RUN at 0x0047 ----
      cyc(1'b0, 1'b1, 1'b0);
      fast_ticks(val_of(32'h0047));
      idle(4);
      tick_evt(1, 3, SS, 1'b1, 1'b0);
      chk("ss_tick_bcd", 32'(BCD_OUT), 32'h0048);
      chk("ss_tick_run", 32'(RUNNING), 32'h0);

      // ---- asynchronous reset mid-count at 0x0321 ----
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 1'b0);
      fast_ticks(val_of(32'h0321));
      idle(4);
      chk("pre_rst_bcd", 32'(BCD_OUT), 32'h0321);
      #2;
      RESET_N = 1'b0;
      #1;
      chk("arst_bcd",     32'(BCD_OUT),   32'h0);
      chk("arst_running", 32'(RUNNING),   32'h0);
      chk("arst_seen",    32'(TICK_SEEN), 32'h0);
      chk("arst_wrap",    32'(WRAP),      32'h0);
      model_reset();
      @(negedge CLK_IN);
      RESET_N = 1'b1;
      s0 = n_seen;
      repeat (3) cyc(1'b1, 1'b0, 1'b0);
      chk("rearm_no_seen", 32'(n_seen - s0), 32'd0);
      idle(2);
      tick_evt(1, 3, -1, 1'b0, 1'b0);
      chk("rearm_seen", 32'(n_seen - s0), 32'd1);

      // ---- wrap-around at the all-max count ----
      cyc(1'b0, 1'b1, 1'b0);
      fast_ticks(mod_max() - 1);
      idle(4);
      chk("max_bcd", 32'(BCD_OUT), MINSEC ? 32'h5959 : 32'h9999);
      w0 = n_wrap;
      tick_evt(1, 5, -1, 1'b0, 1'b0);
      chk("wrap_bcd",   32'(BCD_OUT),     32'h0000);
      chk("wrap_count", 32'(n_wrap - w0), 32'd1);
      chk("wrap_run",   32'(RUNNING),     32'h1);

      // ---- random control and tick traffic ----
      rnd_tck = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 2) == 0) rnd_tck = ~rnd_tck;
         cyc(rnd_tck,
             ($urandom_range(0, 24) == 0),
             ($urandom_range(0, 299) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tick_bcd_counter.md
Name: tick_bcd_counter

Overview:
- Downstream consumer of the slow square-wave clock divider output (nominal 1,000,000 CLK_IN cycles per period).
- Synchronizes that slow clock into the CLK_IN domain and detects its rising edges.
- Runs a multi-digit BCD event counter from those edges, under a start/stop/clear control state machine.
- Its BCD outputs feed display/readout logic.

Parameters:
DIGITS, 4, number of BCD digits; BCD_OUT width = 4*DIGITS; legal values 2..8.
SYNC_STAGES, 2, flip-flop depth of the TICK_CLK synchronizer; legal values 2..4.

Ports:
CLK_IN  input  1  system clock; all logic is rising-edge on CLK_IN.
RESET_N  input  1  asynchronous, active-low reset.
TICK_CLK  input  1  slow divided clock; treated as asynchronous, only rising edges are used.
START_STOP  input  1  single-cycle control pulse; toggles run/pause.
CLEAR  input  1  single-cycle control pulse; zeroes the count and returns to IDLE.
BCD_OUT  output  4*DIGITS  count value; digit 0 = BCD_OUT[3:0] (least significant).
RUNNING  output  1  high while the state machine is in RUN.
TICK_SEEN  output  1  one-cycle pulse per detected TICK_CLK rising edge, in any state.
WRAP  output  1  one-cycle pulse when the count rolls from its maximum to zero.

Behaviour:
- Interface: reset RESET_N, asynchronous, active-low; clock CLK_IN.
- Reset values: BCD_OUT = 0, RUNNING = 0, TICK_SEEN = 0, WRAP = 0, state = IDLE, synchronizer flops = 0, edge-history flop = 0.
- Synchronizer: a chain of SYNC_STAGES flops plus one history flop. tick_edge = last_stage & ~history.
- Latency: if TICK_CLK is first sampled high at CLK_IN edge k, BCD_OUT and TICK_SEEN update at edge k+SYNC_STAGES.
  - TICK_SEEN is high for exactly one cycle per TICK_CLK rising edge.
  - A TICK_CLK high level held for many cycles produces a single pulse.
- Arming: the edge detector is disarmed for SYNC_STAGES+1 cycles after RESET_N deasserts. During that window there is no TICK_SEEN and no count, even if TICK_CLK is already high.
- State machine (three states):
  - IDLE: count held at 0. START_STOP -> RUN.
  - RUN: each tick_edge increments the count. START_STOP -> PAUSE.
  - PAUSE: count held. START_STOP -> RUN.
  - Any state: CLEAR -> IDLE, with BCD_OUT cleared on the same edge.
- Priority within one cycle: CLEAR > tick > START_STOP.
  - CLEAR together with a tick: result is 0, no WRAP.
  - Tick and START_STOP together in RUN: the tick is counted, then the state moves to PAUSE.
  - Tick and START_STOP together in PAUSE or IDLE: not counted, then the state moves to RUN.
- Increment rule: digit 0 increments by 1.
  - A digit at its maximum returns to 0 and carries into the next digit, rippling within the same cycle.
  - Digit maximum is 9 unless the optional feature changes it.
- Wrap-around: when all digits are at maximum, a tick sets BCD_OUT to 0 and pulses WRAP for one cycle, aligned with the BCD_OUT update. The state stays RUN.
- RUNNING is a registered decode of state == RUN, with zero extra latency relative to the state flop.
- START_STOP or CLEAR held high for several cycles is treated as one pulse per cycle. The bench drives single-cycle pulses only.
- Reset mid-operation returns all outputs to their reset values immediately; the count is not preserved.

Optional Feature:
Macro: TICK_BCD_MINSEC_EN
- Defined: odd-indexed digits (1, 3, 5, ...) have maximum 5 and even-indexed digits have maximum 9, giving MM:SS-style counting.
  - DIGITS=4 range is 00:00..59:59.
  - Wrap occurs at 5959 -> 0000.
- Undefined: all digits have maximum 9. DIGITS=4 range is 0000..9999 and wrap occurs at 9999 -> 0000.
- Port list, latency and state machine are identical in both builds.

Test Plan:
- Reset release with TICK_CLK already high, then 10 cycles of idle control -> TICK_SEEN stays 0, BCD_OUT=0x0000, RUNNING=0.
- START_STOP pulse, then 12 TICK_CLK rising edges (period 20 cycles) -> RUNNING=1, 12 TICK_SEEN pulses, BCD_OUT=0x0012. Each update lands 2 cycles after the first sampled-high edge.
- From count 0x0012 in RUN: START_STOP -> PAUSE; 5 ticks -> BCD_OUT stays 0x0012 and TICK_SEEN still pulses 5 times. START_STOP again plus 1 tick -> 0x0013.
- Feature undefined: count to 9999, then one tick -> BCD_OUT=0x0000, WRAP high for exactly 1 cycle, RUNNING stays 1. Feature defined: 0x0059 + 1 tick -> 0x0100; 0x5959 + 1 tick -> 0x0000 with WRAP.
- Same-cycle events:
  - CLEAR and tick_edge together at count 0x0047 -> 0x0000, IDLE, no WRAP.
  - START_STOP and tick_edge together in RUN at 0x0047 -> 0x0048, then PAUSE.
- Assert RESET_N low mid-count at 0x0321 for 1 cycle -> all outputs 0 asynchronously. After release, TICK_SEEN is suppressed for 3 cycles (SYNC_STAGES=2).
